// File: rtl/lab2_proc_mem_arb.sv
// Two-to-one memory request arbiter that shares one memory port and steers responses back by opaque[7].
// Define LAB2_PROC_MEM_ARB_FIXED_PRIO_EN for fixed dmem-over-imem priority instead of round-robin.

package lab2_proc_mem_arb_pkg;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module lab2_proc_mem_arb
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int p_max_inflight = 2
) (
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4B_t  imemreq_msg,
    input  logic         imemreq_val,
    output logic         imemreq_rdy,

    input  mem_req_4B_t  dmemreq_msg,
    input  logic         dmemreq_val,
    output logic         dmemreq_rdy,

    output mem_req_4B_t  memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,

    input  mem_resp_4B_t memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy,

    output mem_resp_4B_t imemresp_msg,
    output logic         imemresp_val,
    input  logic         imemresp_rdy,

    output mem_resp_4B_t dmemresp_msg,
    output logic         dmemresp_val,
    input  logic         dmemresp_rdy
);

    localparam logic [2:0] MAX_INFLIGHT = 3'(p_max_inflight);

    logic [2:0] imem_cnt;
    logic [2:0] dmem_cnt;
    logic       lock;
    logic       lock_port;
    logic       imem_full;
    logic       dmem_full;
    logic       imem_elig;
    logic       dmem_elig;
    logic       grant;
    logic       req_fire;
    logic       resp_fire;
    logic       resp_port;
    logic       imem_inc;
    logic       imem_dec;
    logic       dmem_inc;
    logic       dmem_dec;

    function automatic logic [2:0] next_cnt(input logic [2:0] cnt, input logic inc,
                                            input logic dec);
        if (inc && !dec)
            return cnt + 3'd1;
        if (dec && !inc && cnt != 3'd0)
            return cnt - 3'd1;
        return cnt;
    endfunction

    assign imem_full = (imem_cnt >= MAX_INFLIGHT);
    assign dmem_full = (dmem_cnt >= MAX_INFLIGHT);
    assign imem_elig = imemreq_val && !imem_full;
    assign dmem_elig = dmemreq_val && !dmem_full;

`ifdef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        if (lock)
            grant = lock_port;
        else
            grant = dmem_elig;
    end
`else
    logic last_grant;

    // A tie goes to the port that did not win last; otherwise the lone eligible port wins.
    always_comb begin
        if (lock)
            grant = lock_port;
        else if (imem_elig && dmem_elig)
            grant = ~last_grant;
        else
            grant = dmem_elig;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (req_fire)
            last_grant <= grant;
    end
`endif

    assign memreq_val  = !reset && (grant ? dmem_elig : imem_elig);
    assign imemreq_rdy = !reset && !grant && memreq_rdy && !imem_full;
    assign dmemreq_rdy = !reset &&  grant && memreq_rdy && !dmem_full;
    assign req_fire    = memreq_val && memreq_rdy;

    always_comb begin
        memreq_msg           = grant ? dmemreq_msg : imemreq_msg;
        memreq_msg.opaque[7] = grant;
    end

    assign resp_port    = memresp_msg.opaque[7];
    assign imemresp_val = !reset && memresp_val && !resp_port;
    assign dmemresp_val = !reset && memresp_val &&  resp_port;
    assign memresp_rdy  = !reset && (resp_port ? dmemresp_rdy : imemresp_rdy);
    assign resp_fire    = memresp_val && memresp_rdy;

    always_comb begin
        imemresp_msg           = memresp_msg;
        imemresp_msg.opaque[7] = 1'b0;
    end

    assign dmemresp_msg = imemresp_msg;

    assign imem_inc = req_fire  && !grant;
    assign dmem_inc = req_fire  &&  grant;
    assign imem_dec = resp_fire && !resp_port;
    assign dmem_dec = resp_fire &&  resp_port;

    // Lock holds the grant while a presented request is stalled so its message stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_cnt  <= 3'd0;
            dmem_cnt  <= 3'd0;
            lock      <= 1'b0;
            lock_port <= 1'b0;
        end else begin
            lock     <= memreq_val && !memreq_rdy;
            if (memreq_val && !memreq_rdy)
                lock_port <= grant;
            imem_cnt <= next_cnt(imem_cnt, imem_inc, imem_dec);
            dmem_cnt <= next_cnt(dmem_cnt, dmem_inc, dmem_dec);
        end
    end

`ifndef SYNTHESIS
    logic [2:0] quiet_cnt;

    // Responses to requests issued before a reset may still trickle in for a few cycles.
    always_ff @(posedge clk) begin
        if (reset)
            quiet_cnt <= 3'd4;
        else if (quiet_cnt != 3'd0)
            quiet_cnt <= quiet_cnt - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset && quiet_cnt == 3'd0) begin
            if (imem_dec && !imem_inc && imem_cnt == 3'd0)
                $error("lab2_proc_mem_arb: imem response with no request in flight");
            if (dmem_dec && !dmem_inc && dmem_cnt == 3'd0)
                $error("lab2_proc_mem_arb: dmem response with no request in flight");
        end
    end
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arb.sv
// Scoreboard bench for lab2_proc_mem_arb: directed scenarios plus randomized traffic against a reference model.
module tb_lab2_proc_mem_arb;
    import lab2_proc_mem_arb_pkg::*;

    localparam int MAXF = 2;
`ifdef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    mem_req_4B_t  imemreq_msg, dmemreq_msg, memreq_msg;
    logic         imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy, memreq_val, memreq_rdy;
    mem_resp_4B_t memresp_msg, imemresp_msg, dmemresp_msg;
    logic         memresp_val, memresp_rdy, imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;

    lab2_proc_mem_arb #(.p_max_inflight(MAXF)) dut (
        .clk(clk), .reset(reset),
        .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
        .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
        .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy)
    );

    typedef struct {
        int           cyc;
        logic [127:0] msg;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int           cnt_m[2];
    bit           lock_m, lockp_m, last_m;
    bit           sv[2];
    mem_req_4B_t  smsg[2];
    mem_req_4B_t  pend[$];
    bit           rv;
    int           ridx;
    mem_resp_4B_t rmsg;

    // Traffic knobs (percent) and directed injections
    int           pv[2], pmrdy, presp, prr[2];
    bit           inj_v[2];
    mem_req_4B_t  inj_msg[2];
    bit           inj_resp;
    logic [31:0]  inj_data;

    // Predictions for the cycle in progress, applied at the next edge
    bit           fire_req_s, g_s, mval_s, mrdy_s, fire_resp_s, rport_s;
    mem_req_4B_t  req_out_s;

    exp_t req_q[$], iresp_q[$], dresp_q[$];
    int   fire_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic mem_req_4B_t rand_req();
        mem_req_4B_t m;
        m.msg_type = 3'($urandom_range(1));
        m.opaque   = {1'b0, 7'($urandom)};
        m.addr     = $urandom;
        m.len      = 2'($urandom);
        m.data     = $urandom;
        return m;
    endfunction

    task automatic tick(input bit rst);
        bit           mrdy, irr, drr, e0, e1, g, mval;
        logic [31:0]  d;
        mem_resp_4B_t r;
        exp_t         x;
        @(posedge clk);
        if (reset) begin
            cnt_m[0] = 0; cnt_m[1] = 0;
            lock_m = 0; lockp_m = 0; last_m = 1;
        end else begin
            if (fire_req_s) begin
                cnt_m[g_s]++;
                last_m = g_s;
                pend.push_back(req_out_s);
                sv[g_s] = 0;
            end
            if (fire_resp_s) begin
                if (cnt_m[rport_s] > 0) cnt_m[rport_s]--;
                pend.delete(ridx);
                rv = 0;
            end
            lock_m = mval_s && !mrdy_s;
            if (lock_m) lockp_m = g_s;
        end
        #1;
        cyc++;
        reset = rst;
        for (int p = 0; p < 2; p++) begin
            if (!sv[p]) begin
                if (inj_v[p]) begin
                    sv[p] = 1; smsg[p] = inj_msg[p]; inj_v[p] = 0;
                end else if (roll(pv[p])) begin
                    sv[p] = 1; smsg[p] = rand_req();
                end
            end
        end
        if (!rv && pend.size() > 0) begin
            if (inj_resp) begin
                ridx = 0; rv = 1; d = inj_data; inj_resp = 0;
            end else if (roll(presp)) begin
                ridx = int'($urandom_range(pend.size() - 1)); rv = 1; d = $urandom;
            end
            if (rv) begin
                rmsg.msg_type = pend[ridx].msg_type;
                rmsg.opaque   = pend[ridx].opaque;
                rmsg.test     = 2'd0;
                rmsg.len      = pend[ridx].len;
                rmsg.data     = d;
            end
        end
        mrdy = roll(pmrdy);
        irr  = roll(prr[0]);
        drr  = roll(prr[1]);

        imemreq_val  = sv[0]; imemreq_msg = smsg[0];
        dmemreq_val  = sv[1]; dmemreq_msg = smsg[1];
        memreq_rdy   = mrdy;
        memresp_val  = rv;    memresp_msg = rmsg;
        imemresp_rdy = irr;   dmemresp_rdy = drr;

        e0 = sv[0] && cnt_m[0] < MAXF;
        e1 = sv[1] && cnt_m[1] < MAXF;
        if (lock_m)        g = lockp_m;
        else if (e0 && e1) g = FIXED ? 1'b1 : !last_m;
        else               g = e1;
        mval = !rst && (g ? e1 : e0);
        fire_req_s = mval && mrdy;
        g_s = g; mval_s = mval; mrdy_s = mrdy;
        req_out_s = smsg[g];
        req_out_s.opaque[7] = g;
        if (fire_req_s) begin
            x.cyc = cyc; x.msg = 128'(req_out_s);
            req_q.push_back(x);
        end
        rport_s = rmsg.opaque[7];
        fire_resp_s = !rst && rv && (rport_s ? drr : irr);
        if (fire_resp_s) begin
            r = rmsg; r.opaque[7] = 1'b0;
            x.cyc = cyc; x.msg = 128'(r);
            if (rport_s) dresp_q.push_back(x);
            else         iresp_q.push_back(x);
        end
    endtask

    task automatic set_knobs(input int v0, input int v1, input int mr, input int rs,
                             input int r0, input int r1);
        pv[0] = v0; pv[1] = v1; pmrdy = mr; presp = rs; prr[0] = r0; prr[1] = r1;
    endtask

    task automatic idle_drain();
        int n;
        set_knobs(0, 0, 100, 100, 100, 100);
        n = 0;
        while ((sv[0] || sv[1] || rv || pend.size() > 0) && n < 200) begin
            tick(0);
            n++;
        end
        tick(0);
        check("drain_done", 128'(n < 200), 128'(1));
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1)
                check("reset_outputs_low", 128'({memreq_val, imemreq_rdy, dmemreq_rdy, memresp_rdy,
                                                 imemresp_val, dmemresp_val}), 128'(0));
            if (memreq_val && memreq_rdy) begin
                fire_log.push_back(int'(memreq_msg.opaque[7]));
                check("req_expected", 128'(req_q.size() > 0), 128'(1));
                if (req_q.size() > 0) begin
                    e = req_q.pop_front();
                    check("req_cycle", 128'(cyc), 128'(e.cyc));
                    check("req_msg", 128'(memreq_msg), e.msg);
                end
            end
            if (imemresp_val && imemresp_rdy) begin
                check("iresp_expected", 128'(iresp_q.size() > 0), 128'(1));
                if (iresp_q.size() > 0) begin
                    e = iresp_q.pop_front();
                    check("iresp_cycle", 128'(cyc), 128'(e.cyc));
                    check("iresp_msg", 128'(imemresp_msg), e.msg);
                end
            end
            if (dmemresp_val && dmemresp_rdy) begin
                check("dresp_expected", 128'(dresp_q.size() > 0), 128'(1));
                if (dresp_q.size() > 0) begin
                    e = dresp_q.pop_front();
                    check("dresp_cycle", 128'(cyc), 128'(e.cyc));
                    check("dresp_msg", 128'(dmemresp_msg), e.msg);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_rr[4];
        reset = 1'b1;
        imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0; rmsg = '0;
        imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
        imemresp_rdy = 0; dmemresp_rdy = 0;
        sv[0] = 0; sv[1] = 0; rv = 0; inj_v[0] = 0; inj_v[1] = 0; inj_resp = 0;
        cnt_m[0] = 0; cnt_m[1] = 0; lock_m = 0; lockp_m = 0; last_m = 1;
        fire_req_s = 0; fire_resp_s = 0; mval_s = 0; mrdy_s = 0; g_s = 0; rport_s = 0;
        req_out_s = '0;

        // Tie arbitration right out of reset
        set_knobs(100, 100, 100, 100, 100, 100);
        repeat (3) tick(1);
        base = fire_log.size();
        repeat (8) tick(0);
        #3;
        if (FIXED) exp_rr = '{1, 1, 1, 1};
        else       exp_rr = '{0, 1, 0, 1};
        check("tie_fire_count", 128'(fire_log.size() >= base + 4), 128'(1));
        for (int i = 0; i < 4; i++)
            if (fire_log.size() > base + i)
                check($sformatf("tie_grant_%0d", i), 128'(fire_log[base + i]), 128'(exp_rr[i]));

        // Lock under backpressure
        idle_drain();
        set_knobs(0, 0, 0, 0, 100, 100);
        inj_msg[0] = rand_req(); inj_msg[0].addr = 32'h200; inj_v[0] = 1;
        tick(0); #3;
        check("lock_addr_0", 128'(memreq_msg.addr), 128'(32'h200));
        inj_msg[1] = rand_req(); inj_v[1] = 1;
        for (int i = 1; i < 3; i++) begin
            tick(0); #3;
            check($sformatf("lock_addr_%0d", i), 128'(memreq_msg.addr), 128'(32'h200));
            check($sformatf("lock_drdy_%0d", i), 128'({dmemreq_val, dmemreq_rdy}), 128'(2'b10));
        end
        pmrdy = 100;
        tick(0); #3;
        check("lock_fire", 128'({memreq_msg.addr, imemreq_rdy, dmemreq_rdy}), 128'({32'h200, 2'b10}));
        tick(0); #3;
        check("lock_next_dmem", 128'({memreq_val, memreq_msg.opaque[7], dmemreq_rdy}), 128'(3'b111));

        // In-flight limit
        idle_drain();
        set_knobs(100, 0, 100, 0, 100, 100);
        tick(0); tick(0);
        tick(0); #3;
        check("inflight_full", 128'({imemreq_val, imemreq_rdy}), 128'(2'b10));
        presp = 100;
        tick(0);
        presp = 0;
        tick(0); #3;
        check("inflight_reenable", 128'({imemreq_val, imemreq_rdy}), 128'(2'b11));
        pv[1] = 100;
        tick(0); #3;
        check("inflight_other_port", 128'({imemreq_rdy, dmemreq_rdy, memreq_val}), 128'(3'b011));

        // Response routing
        idle_drain();
        set_knobs(0, 0, 100, 0, 100, 0);
        inj_msg[1] = rand_req(); inj_msg[1].opaque = 8'h00; inj_v[1] = 1;
        tick(0);
        inj_resp = 1; inj_data = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick(0); #3;
            check($sformatf("route_d_stall_%0d", i), 128'({imemresp_val, dmemresp_val, memresp_rdy}),
                  128'(3'b010));
            check($sformatf("route_d_msg_%0d", i), 128'({memresp_msg.opaque, dmemresp_msg.opaque,
                  dmemresp_msg.data}), 128'({8'h80, 8'h00, 32'hDEADBEEF}));
        end
        prr[1] = 100;
        tick(0); #3;
        check("route_d_fire", 128'(memresp_rdy), 128'(1));
        inj_msg[0] = rand_req(); inj_msg[0].opaque = 8'h00; inj_v[0] = 1;
        tick(0);
        inj_resp = 1; inj_data = $urandom;
        tick(0); #3;
        check("route_i", 128'({imemresp_val, dmemresp_val, memresp_rdy, imemresp_msg.opaque}),
              128'({3'b101, 8'h00}));

        // Request and response fire together on dmem
        idle_drain();
        set_knobs(0, 0, 100, 0, 100, 100);
        inj_msg[1] = rand_req(); inj_v[1] = 1;
        tick(0);
        inj_msg[1] = rand_req(); inj_v[1] = 1; inj_resp = 1; inj_data = $urandom;
        tick(0); #3;
        check("simul_both_fire", 128'({dmemreq_rdy, memresp_rdy, dmemresp_val}), 128'(3'b111));
        inj_msg[1] = rand_req(); inj_v[1] = 1;
        tick(0); #3;
        check("simul_cnt_one", 128'({dmemreq_val, dmemreq_rdy}), 128'(2'b11));
        inj_msg[1] = rand_req(); inj_v[1] = 1;
        tick(0); #3;
        check("simul_cnt_full", 128'({dmemreq_val, dmemreq_rdy}), 128'(2'b10));

        // Randomized traffic
        idle_drain();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                set_knobs(int'($urandom_range(95, 5)), int'($urandom_range(95, 5)),
                          int'($urandom_range(100, 20)), int'($urandom_range(100, 10)),
                          int'($urandom_range(100, 20)), int'($urandom_range(100, 20)));
            tick(0);
        end

        // Reset with requests still outstanding at the memory
        idle_drain();
        set_knobs(100, 0, 100, 0, 100, 100);
        tick(0); tick(0);
        set_knobs(0, 0, 100, 100, 100, 100);
        tick(1); tick(1);
        repeat (6) tick(0);
        check("stale_drained", 128'(pend.size()), 128'(0));
        set_knobs(100, 0, 100, 0, 100, 100);
        tick(0); tick(0);
        tick(0); #3;
        check("post_reset_full", 128'({imemreq_val, imemreq_rdy}), 128'(2'b10));

        idle_drain();
        #5;
        check("req_q_empty", 128'(req_q.size()), 128'(0));
        check("iresp_q_empty", 128'(iresp_q.size()), 128'(0));
        check("dresp_q_empty", 128'(dresp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
